bk_mem_arbiter: RTL and testbench

- Sequences the CPU's Q-bus-style cycles (SYNC/DIN/DOUT/WTBT/RPLY) onto one shared single-port 16K-word RAM.
- Shares that RAM with a video scan-out fetcher.
- Forwards upper-half addresses (100000–177777 octal) to an external ROM/IO port and times out unanswered cycles into a bus-error pulse for the CPU's error_i.
- Sits between the vm1 core and the memory/IO fabric.

---
 rtl/bk_mem_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_bk_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bk_mem_arbiter.sv
// Q-bus cycle sequencer sharing one single-port RAM between the CPU and video scan-out,
// forwarding the upper 32 KB to an external port. Define BUSERR_TIMEOUT_EN to enable the bus-error timeout.
module bk_mem_arbiter #(
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  input  logic        cpu_sync,
  input  logic        cpu_din,
  input  logic        cpu_dout,
  input  logic        cpu_wtbt,
  output logic        cpu_rply,
  output logic        cpu_buserr,
  input  logic        vid_req,
  input  logic [13:0] vid_addr,
  output logic        vid_ack,
  output logic [15:0] vid_data,
  output logic [13:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_we,
  output logic [1:0]  mem_be,
  output logic        ext_sel,
  input  logic [15:0] ext_rdata,
  input  logic        ext_rply,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_VID_RD, S_VID_ACK, S_CPU_ACC, S_CPU_DATA,
    S_CPU_WAIT, S_CPU_RPLY, S_EXT, S_ERR
  } state_t;

  localparam logic [2:0] WS_LAST = 3'(WAIT_STATES - 1);

  state_t      state_q, state_d;
  logic        last_vid_q, last_vid_d;
  logic [2:0]  wait_q, wait_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic [15:0] vid_data_q, vid_data_d;
`ifdef BUSERR_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0]  to_q, to_d;
  logic        buserr_q, buserr_d;
`endif

  logic       cpu_req, ram_req, ext_req;
  logic [7:0] byte_lane;
  logic [1:0] cpu_be;

  assign cpu_req   = cpu_sync & (cpu_din | cpu_dout);
  assign ram_req   = cpu_req & ~cpu_addr[15];
  assign ext_req   = cpu_req & cpu_addr[15];
  assign byte_lane = cpu_addr[0] ? mem_rdata[15:8] : mem_rdata[7:0];
  assign cpu_be    = cpu_wtbt ? (cpu_addr[0] ? 2'b10 : 2'b01) : 2'b11;

  always_comb begin
    state_d     = state_q;
    last_vid_d  = last_vid_q;
    wait_d      = wait_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_data_d  = vid_data_q;
`ifdef BUSERR_TIMEOUT_EN
    to_d        = to_q;
    buserr_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        // Contention only with a RAM-bound CPU cycle; the side not served last wins.
        if (vid_req && !(ram_req && last_vid_q)) begin
          state_d = S_VID_RD;
        end else if (ram_req) begin
          state_d = S_CPU_ACC;
        end else if (ext_req) begin
          state_d = S_EXT;
`ifdef BUSERR_TIMEOUT_EN
          to_d    = '0;
`endif
        end
      end
      S_VID_RD: state_d = S_VID_ACK;
      S_VID_ACK: begin
        vid_data_d = mem_rdata;
        last_vid_d = 1'b1;
        state_d    = S_IDLE;
      end
      S_CPU_ACC: begin
        if (!cpu_sync) begin
          state_d = S_IDLE;
        end else if (cpu_dout) begin
          wait_d  = '0;
          state_d = (WAIT_STATES == 0) ? S_CPU_RPLY : S_CPU_WAIT;
        end else begin
          state_d = S_CPU_DATA;
        end
      end
      S_CPU_DATA: begin
        if (!cpu_sync) begin
          state_d = S_IDLE;
        end else begin
          cpu_rdata_d = cpu_wtbt ? {8'h00, byte_lane} : mem_rdata;
          wait_d      = '0;
          state_d     = (WAIT_STATES == 0) ? S_CPU_RPLY : S_CPU_WAIT;
        end
      end
      S_CPU_WAIT: begin
        if (!cpu_sync) begin
          state_d = S_IDLE;
        end else if (wait_q == WS_LAST) begin
          state_d = S_CPU_RPLY;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      S_CPU_RPLY: begin
        if (!cpu_req) begin
          last_vid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_EXT: begin
        if (!cpu_sync) begin
          state_d = S_IDLE;
`ifdef BUSERR_TIMEOUT_EN
        end else if (!ext_rply) begin
          if (to_q == TO_LAST) begin
            buserr_d = 1'b1;
            state_d  = S_ERR;
          end else begin
            to_d = to_q + 8'd1;
          end
`endif
        end
      end
      S_ERR: begin
        if (!cpu_sync) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      last_vid_q  <= 1'b0;
      wait_q      <= '0;
      cpu_rdata_q <= '0;
      vid_data_q  <= '0;
`ifdef BUSERR_TIMEOUT_EN
      to_q        <= '0;
      buserr_q    <= 1'b0;
`endif
    end else if (ce) begin
      state_q     <= state_d;
      last_vid_q  <= last_vid_d;
      wait_q      <= wait_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_data_q  <= vid_data_d;
`ifdef BUSERR_TIMEOUT_EN
      to_q        <= to_d;
      buserr_q    <= buserr_d;
`endif
    end
  end

  // Outputs decode from the registered state so reset clears every strobe at once.
  always_comb begin
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (state_q)
      S_VID_RD, S_VID_ACK: begin
        mem_addr = vid_addr;
        mem_be   = 2'b11;
      end
      S_CPU_ACC, S_CPU_DATA: begin
        mem_addr = cpu_addr[14:1];
        mem_be   = cpu_be;
        if (state_q == S_CPU_ACC && cpu_dout) begin
          mem_wdata = cpu_wtbt ? {cpu_wdata[7:0], cpu_wdata[7:0]} : cpu_wdata;
          mem_we    = cpu_sync;
        end
      end
      default: ;
    endcase
  end

  assign vid_ack   = (state_q == S_VID_ACK);
  assign vid_data  = vid_ack ? mem_rdata : vid_data_q;
  assign ext_sel   = (state_q == S_EXT);
  assign cpu_rdata = ext_sel ? ext_rdata : cpu_rdata_q;
  assign cpu_rply  = ((state_q == S_CPU_RPLY) && cpu_req) || (ext_sel && ext_rply);
  assign dbg_state = state_q;
`ifdef BUSERR_TIMEOUT_EN
  assign cpu_buserr = buserr_q;
`else
  assign cpu_buserr = 1'b0;
`endif

endmodule

// File: tb/tb_bk_mem_arbiter.sv
// Directed and randomized bench for bk_mem_arbiter with a word-array RAM behind it and a
// transaction-level reference memory; expectations follow BUSERR_TIMEOUT_EN when defined.
module tb_bk_mem_arbiter;
  localparam int WS = 2;
  localparam int TO = 15;

  logic        clk = 1'b0, reset = 1'b1, ce = 1'b1, ce_rand = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic        cpu_sync = 1'b0, cpu_din = 1'b0, cpu_dout = 1'b0, cpu_wtbt = 1'b0;
  logic        cpu_rply, cpu_buserr;
  logic        vid_req = 1'b0, vid_ack;
  logic [13:0] vid_addr = '0, mem_addr;
  logic [15:0] vid_data, mem_wdata, mem_rdata = '0, ext_rdata = '0;
  logic        mem_we, ext_sel, ext_rply = 1'b0;
  logic [1:0]  mem_be;
  logic [3:0]  dbg_state;

  int n_cmp = 0, n_fail = 0, cyc = 0, we_cnt = 0, buserr_cnt = 0;
  logic [1:0]  we_be;
  logic [13:0] we_addr;
  logic [15:0] we_data;
  logic [15:0] ram     [16384];
  logic [15:0] ref_mem [16384];
  logic [15:0] exp_q[$];

  bk_mem_arbiter #(.WAIT_STATES(WS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_sync(cpu_sync), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_wtbt(cpu_wtbt),
    .cpu_rply(cpu_rply), .cpu_buserr(cpu_buserr),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_we(mem_we),
    .mem_be(mem_be), .ext_sel(ext_sel), .ext_rdata(ext_rdata), .ext_rply(ext_rply),
    .dbg_state(dbg_state)
  );

  // Clock, clock-enable and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial forever begin
    @(negedge clk);
    #1 ce = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Synchronous RAM with byte lanes; read data appears one enabled cycle after the address
  initial for (int i = 0; i < 16384; i++) begin ram[i] = '0; ref_mem[i] = '0; end
  always @(posedge clk) begin
    if (ce) begin
      if (mem_we && mem_be[0]) ram[mem_addr][7:0]  <= mem_wdata[7:0];
      if (mem_we && mem_be[1]) ram[mem_addr][15:8] <= mem_wdata[15:8];
      mem_rdata <= ram[mem_addr];
    end
  end

  // Write-strobe and bus-error pulse monitor, sampled mid low phase
  always @(negedge clk) begin
    #2;
    if (ce && mem_we) begin
      we_cnt  <= we_cnt + 1;
      we_be   <= mem_be;
      we_addr <= mem_addr;
      we_data <= mem_wdata;
    end
    if (ce && cpu_buserr) buserr_cnt <= buserr_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit after %0d comparisons", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_write(input logic [15:0] a, input logic [15:0] d, input logic b);
    if (!b)        ref_mem[a[14:1]]       = d;
    else if (a[0]) ref_mem[a[14:1]][15:8] = d[7:0];
    else           ref_mem[a[14:1]][7:0]  = d[7:0];
  endfunction

  function automatic logic [15:0] ref_read(input logic [15:0] a, input logic b);
    logic [15:0] w;
    w = ref_mem[a[14:1]];
    if (!b) return w;
    return {8'h00, a[0] ? w[15:8] : w[7:0]};
  endfunction

  task automatic wait_ce(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (ce) k++;
    end
  endtask

  // One full CPU bus cycle; lat counts enabled edges from request to RPLY
  task automatic cpu_cycle(input logic [15:0] addr, input logic [15:0] wdata, input logic is_wr,
                           input logic is_byte, output logic [15:0] rdata, output int lat,
                           output int t_rply);
    logic ok;
    ok = 1'b0; lat = 0; t_rply = 0; rdata = '0;
    @(posedge clk); #1;
    cpu_addr = addr; cpu_wdata = wdata; cpu_wtbt = is_byte;
    cpu_din = !is_wr; cpu_dout = is_wr; cpu_sync = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk);
      if (ce) lat++;
      #1;
      if (cpu_rply === 1'b1) begin ok = 1'b1; rdata = cpu_rdata; t_rply = cyc; end
    end
    cpu_sync = 1'b0; cpu_din = 1'b0; cpu_dout = 1'b0; cpu_wtbt = 1'b0;
    #1;
    check("rply_seen", ok, 1);
    check("rply_release", cpu_rply, 0);
    wait_ce(1);
  endtask

  task automatic vid_fetch(input logic [13:0] a, output logic [15:0] d, output int t_ack);
    logic ok;
    ok = 1'b0; d = '0; t_ack = 0;
    @(posedge clk); #1;
    vid_addr = a; vid_req = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk); #1;
      if (vid_ack === 1'b1) begin ok = 1'b1; d = vid_data; t_ack = cyc; end
    end
    vid_req = 1'b0;
    check("ack_seen", ok, 1);
    wait_ce(1);
  endtask

  initial begin
    logic [15:0] rd, rd2, vd, vd2, a, d, xd;
    logic [13:0] va;
    int lat, tc, tv, w0, b0, n, at_n, op;
    logic seen, rply_seen, bsel;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rply", cpu_rply, 0);    check("rst_buserr", cpu_buserr, 0);
    check("rst_vid_ack", vid_ack, 0);  check("rst_vid_data", vid_data, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_mem_we", mem_we, 0);    check("rst_mem_be", mem_be, 0);
    check("rst_mem_addr", mem_addr, 0); check("rst_ext_sel", ext_sel, 0);
    reset = 1'b0;

    // Word write then word read
    w0 = we_cnt;
    cpu_cycle(16'o001000, 16'o123456, 1'b1, 1'b0, rd, lat, tc);
    ref_write(16'o001000, 16'o123456, 1'b0);
    check("wr_lat", lat, 2 + WS);
    check("wr_pulses", we_cnt - w0, 1);
    check("wr_be", we_be, 2'b11);
    check("wr_addr", we_addr, 14'h100);
    check("wr_data", we_data, 16'o123456);
    cpu_cycle(16'o001000, 16'h0, 1'b0, 1'b0, rd, lat, tc);
    check("rd_lat", lat, 3 + WS);
    check("rd_word", rd, ref_read(16'o001000, 1'b0));

    // Byte writes to both lanes
    w0 = we_cnt;
    cpu_cycle(16'o001001, 16'o000377, 1'b1, 1'b1, rd, lat, tc);
    ref_write(16'o001001, 16'o000377, 1'b1);
    check("bw_pulses", we_cnt - w0, 1);
    check("bw_be_hi", we_be, 2'b10);
    check("bw_data_dup", we_data, 16'hFFFF);
    cpu_cycle(16'o001000, 16'h0, 1'b0, 1'b0, rd, lat, tc);
    check("bw_word_lit", rd, 16'o177456);
    check("bw_word_ref", rd, ref_read(16'o001000, 1'b0));
    cpu_cycle(16'o001001, 16'h0, 1'b0, 1'b1, rd, lat, tc);
    check("br_hi", rd, 16'o000377);
    cpu_cycle(16'o002000, 16'h1255, 1'b1, 1'b1, rd, lat, tc);
    ref_write(16'o002000, 16'h1255, 1'b1);
    check("bw_be_lo", we_be, 2'b01);
    cpu_cycle(16'o002000, 16'h0, 1'b0, 1'b1, rd, lat, tc);
    check("br_lo", rd, ref_read(16'o002000, 1'b1));

    // Arbitration: last grant CPU -> video first; after a lone fetch -> CPU first
    d = 16'($urandom);
    cpu_cycle(16'o003000, d, 1'b1, 1'b0, rd, lat, tc);
    ref_write(16'o003000, d, 1'b0);
    fork
      vid_fetch(14'h300, vd, tv);
      cpu_cycle(16'o001000, 16'h0, 1'b0, 1'b0, rd, lat, tc);
    join
    check("pair1_vid_data", vd, ref_mem[14'h300]);
    check("pair1_cpu_data", rd, ref_read(16'o001000, 1'b0));
    check("pair1_vid_first", tv < tc, 1);
    check("vid_hold", vid_data, ref_mem[14'h300]);
    vid_fetch(14'h100, vd, tv);
    check("lone_vid_data", vd, ref_mem[14'h100]);
    fork
      vid_fetch(14'h300, vd, tv);
      cpu_cycle(16'o001000, 16'h0, 1'b0, 1'b0, rd, lat, tc);
    join
    check("pair2_cpu_first", tc < tv, 1);
    check("pair2_vid_data", vd, ref_mem[14'h300]);

    // External read answered after 4 cycles
    b0 = buserr_cnt;
    xd = 16'($urandom);
    @(posedge clk); #1;
    cpu_addr = 16'o177564; cpu_sync = 1'b1; cpu_din = 1'b1;
    wait_ce(1); #1;
    check("ext_sel_on", ext_sel, 1);
    check("ext_no_rply_yet", cpu_rply, 0);
    wait_ce(3); #1;
    ext_rdata = xd; ext_rply = 1'b1;
    #1;
    check("ext_rply_mirror", cpu_rply, 1);
    check("ext_rdata_pass", cpu_rdata, xd);
    cpu_sync = 1'b0; cpu_din = 1'b0; ext_rply = 1'b0;
    wait_ce(1); #1;
    check("ext_sel_off", ext_sel, 0);
    check("ext_no_buserr", buserr_cnt - b0, 0);

    // External read never answered
    b0 = buserr_cnt; seen = 1'b0; rply_seen = 1'b0; n = 0; at_n = 0;
    @(posedge clk); #1;
    cpu_addr = 16'o172000; cpu_sync = 1'b1; cpu_din = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (ce) n++;
      #1;
      if (cpu_rply === 1'b1) rply_seen = 1'b1;
      if (cpu_buserr === 1'b1 && !seen) begin
        seen = 1'b1; at_n = n;
        check("to_ext_sel_drop", ext_sel, 0);
      end
    end
    check("to_no_rply", rply_seen, 0);
`ifdef BUSERR_TIMEOUT_EN
    check("to_pulse_seen", seen, 1);
    check("to_pulse_time", at_n, TO + 1);
    check("to_pulse_width", buserr_cnt - b0, 1);
`else
    check("to_no_pulse", seen, 0);
    check("to_still_waiting", ext_sel, 1);
`endif
    cpu_sync = 1'b0; cpu_din = 1'b0;
    wait_ce(1); #1;
    check("to_release_sel", ext_sel, 0);
    check("to_release_err", cpu_buserr, 0);

    // Abort a RAM read mid-cycle
    rply_seen = 1'b0;
    @(posedge clk); #1;
    cpu_addr = 16'o001000; cpu_sync = 1'b1; cpu_din = 1'b1;
    wait_ce(2); #1;
    cpu_sync = 1'b0; cpu_din = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (cpu_rply === 1'b1) rply_seen = 1'b1;
    end
    check("abort_no_rply", rply_seen, 0);

    // Reset during the wait phase of a read
    @(posedge clk); #1;
    cpu_addr = 16'o001000; cpu_sync = 1'b1; cpu_din = 1'b1;
    wait_ce(3); #1;
    reset = 1'b1;
    #1;
    check("rst_mid_rply", cpu_rply, 0);
    check("rst_mid_rdata", cpu_rdata, 0);
    check("rst_mid_we", mem_we, 0);
    check("rst_mid_addr", mem_addr, 0);
    cpu_sync = 1'b0; cpu_din = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    vid_fetch(14'h300, vd, tv);
    check("rst_then_vid", vd, ref_mem[14'h300]);

    // Randomized traffic with a gappy clock enable
    ce_rand = 1'b1;
    for (int it = 0; it < 40; it++) begin
      op   = $urandom_range(0, 4);
      a    = 16'o001000 + 16'($urandom_range(0, 63));
      d    = 16'($urandom);
      bsel = 1'($urandom_range(0, 1));
      va   = 14'h100 + 14'($urandom_range(0, 31));
      case (op)
        0, 1: begin
          if (op == 0) a[0] = 1'b0;
          w0 = we_cnt;
          cpu_cycle(a, d, 1'b1, op == 1, rd, lat, tc);
          ref_write(a, d, op == 1);
          check("rnd_wr_lat", lat, 2 + WS);
          check("rnd_we_pulses", we_cnt - w0, 1);
        end
        2: begin
          if (!bsel) a[0] = 1'b0;
          exp_q.push_back(ref_read(a, bsel));
          cpu_cycle(a, 16'h0, 1'b0, bsel, rd, lat, tc);
          check("rnd_rd", rd, exp_q.pop_front());
          check("rnd_rd_lat", lat, 3 + WS);
        end
        3: begin
          exp_q.push_back(ref_mem[va]);
          vid_fetch(va, vd, tv);
          check("rnd_vid", vd, exp_q.pop_front());
        end
        default: begin
          a[0] = 1'b0;
          exp_q.push_back(ref_read(a, 1'b0));
          exp_q.push_back(ref_mem[va]);
          fork
            cpu_cycle(a, 16'h0, 1'b0, 1'b0, rd2, lat, tc);
            vid_fetch(va, vd2, tv);
          join
          check("rnd_pair_cpu", rd2, exp_q.pop_front());
          check("rnd_pair_vid", vd2, exp_q.pop_front());
        end
      endcase
    end
    ce_rand = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
